// File: rtl/proc_loader.sv
// Boot-time program loader: takes a little-endian byte stream (4-byte start address, 4-byte word count,
// then the data words), writes each assembled 32-bit word to memory and holds the processor in reset until the load completes.
// Latency: the write strobe is registered and appears in the cycle after the 4th byte of a word. Backpressure: in_rdy drops during WRITE, DONE and ERR.
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   in_val/in_rdy/in_data byte stream (a byte transfers when in_val & in_rdy)
//   load_start            one-cycle pulse that re-arms the loader from DONE or ERR
//   ext_dmemreq_*         memory write port: one-cycle strobe per word, with byte address and data
//   proc_rst              processor reset; low only in DONE
//   busy/done/err         status flags, registered together with the state
//   words_written         number of words written by the current load
module proc_loader #(
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [7:0]  in_data,
  input  logic        load_start,
  output logic        ext_dmemreq_val,
  output logic        ext_dmemreq_type,
  output logic [31:0] ext_dmemreq_addr,
  output logic [31:0] ext_dmemreq_wdata,
  output logic        proc_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] words_written
);

  typedef enum logic [2:0] {
    S_HDR_ADDR, S_HDR_CNT, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;          // byte position within the current 32-bit field
  logic [23:0] asm_q, asm_d;          // bytes 0..2 of the field; byte 3 is taken straight from in_data
  logic [31:0] cnt_q, cnt_d;          // word count N from the header
  logic [31:0] wr_addr_q, wr_addr_d;  // address for the next word; wraps at 32 bits
  logic [31:0] words_q, words_d;
  logic        in_rdy_q, in_rdy_d;
  logic        val_q, val_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        proc_rst_q, proc_rst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        acc;
  logic [31:0] field;

  // in_rdy is registered, so it can be qualified here without a combinational path back to in_rdy.
  assign acc   = in_val & in_rdy_q;
  assign field = {in_data, asm_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    words_d   = words_q;
    addr_d    = 32'd0;
    wdata_d   = 32'd0;

    // Collect stream bytes in every state that accepts them; the state logic below
    // only acts when the 4th byte of a field arrives.
    if (acc) begin
      idx_d = idx_q + 2'd1;
      case (idx_q)
        2'd0:    asm_d[7:0]   = in_data;
        2'd1:    asm_d[15:8]  = in_data;
        2'd2:    asm_d[23:16] = in_data;
        default: asm_d        = asm_q;
      endcase
    end

    case (state_q)
      S_HDR_ADDR: begin
        if (acc && idx_q == 2'd3) begin
          wr_addr_d = field;
          state_d   = (field[1:0] != 2'b00) ? S_ERR : S_HDR_CNT;
        end
      end
      S_HDR_CNT: begin
        if (acc && idx_q == 2'd3) begin
          cnt_d = field;
          if (field == 32'd0)                 state_d = S_DONE;
          else if (field > 32'(MAX_WORDS))    state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (acc && idx_q == 2'd3) begin
          state_d = S_WRITE;
          addr_d  = wr_addr_q;
          wdata_d = field;
        end
      end
      S_WRITE: begin
        words_d   = words_q + 32'd1;
        wr_addr_d = wr_addr_q + 32'd4;
        state_d   = (words_q + 32'd1 == cnt_q) ? S_DONE : S_DATA;
      end
      S_DONE, S_ERR: begin
        if (load_start) begin
          state_d = S_HDR_ADDR;
          words_d = 32'd0;
          idx_d   = 2'd0;
        end
      end
      default: state_d = S_HDR_ADDR;
    endcase

    // All outputs are decoded from the next state, so they change in the same cycle as the state.
    in_rdy_d   = (state_d == S_HDR_ADDR) || (state_d == S_HDR_CNT) || (state_d == S_DATA);
    busy_d     = in_rdy_d || (state_d == S_WRITE);
    val_d      = (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    proc_rst_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HDR_ADDR;
      idx_q      <= 2'd0;
      asm_q      <= 24'd0;
      cnt_q      <= 32'd0;
      wr_addr_q  <= 32'd0;
      words_q    <= 32'd0;
      in_rdy_q   <= 1'b1;
      val_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      proc_rst_q <= 1'b1;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      words_q    <= words_d;
      in_rdy_q   <= in_rdy_d;
      val_q      <= val_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      proc_rst_q <= proc_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_rdy            = in_rdy_q;
  assign ext_dmemreq_val   = val_q;
  assign ext_dmemreq_type  = val_q;
  assign ext_dmemreq_addr  = addr_q;
  assign ext_dmemreq_wdata = wdata_q;
  assign proc_rst          = proc_rst_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign words_written     = words_q;

endmodule

// File: tb/tb_proc_loader.sv
module tb_proc_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_val = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        load_start = 1'b0;
  logic        in_rdy;
  logic        ext_dmemreq_val;
  logic        ext_dmemreq_type;
  logic [31:0] ext_dmemreq_addr;
  logic [31:0] ext_dmemreq_wdata;
  logic        proc_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words_written;

  proc_loader #(.MAX_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .load_start(load_start),
    .ext_dmemreq_val(ext_dmemreq_val), .ext_dmemreq_type(ext_dmemreq_type),
    .ext_dmemreq_addr(ext_dmemreq_addr), .ext_dmemreq_wdata(ext_dmemreq_wdata),
    .proc_rst(proc_rst), .busy(busy), .done(done), .err(err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] dat [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, arrive in the
  // cycle right after its 4th byte, and stall the stream.
  always @(negedge clk) begin
    if (rst) begin
      if (ext_dmemreq_val) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", ext_dmemreq_addr, 32'hxxxxxxxx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr", ext_dmemreq_addr, e.addr);
          chk("wr_data", ext_dmemreq_wdata, e.wdata);
          chk("wr_latency", 32'(cyc), 32'(e.cyc));
          chk("wr_type", {31'd0, ext_dmemreq_type}, 32'd1);
          chk("wr_in_rdy", {31'd0, in_rdy}, 32'd0);
          last_addr = ext_dmemreq_addr;
        end
      end else begin
        chk("idle_type", {31'd0, ext_dmemreq_type}, 32'd0);
      end
    end
  end

  // Offers one byte, optionally inserting random gaps; returns the cycle index at
  // which the byte is accepted (the edge that moves cyc to acc_e).
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_e);
    acc_e = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (gap > 0 && $urandom_range(99) < gap) begin
        in_val = 1'b0;
      end else begin
        in_val  = 1'b1;
        in_data = b;
        if (in_rdy) begin
          acc_e = cyc + 1;
          @(posedge clk);
          return;
        end
      end
    end
    chk("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, output int acc_e);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], gap, acc_e);
  endtask

  // Header plus nw data words from dat[]; expected writes go to the scoreboard.
  task automatic load(input logic [31:0] a, input logic [31:0] n, input int nw,
                      input int gap, input bit poke);
    int e;
    exp_t x;
    send_word(a, gap, e);
    send_word(n, gap, e);
    for (int k = 0; k < nw; k++) begin
      send_word(dat[k], gap, e);
      x.addr  = a + 32'(k) * 32'd4;
      x.wdata = dat[k];
      x.cyc   = e;
      sb.push_back(x);
      if (poke && k == 0) begin
        @(negedge clk);
        in_val     = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        chk("poke_busy", {31'd0, busy}, 32'd1);
      end
    end
    @(negedge clk);
    in_val = 1'b0;
    if (nw > 0) @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    in_val     = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("rs_busy", {31'd0, busy}, 32'd1);
    chk("rs_done", {31'd0, done}, 32'd0);
    chk("rs_err", {31'd0, err}, 32'd0);
    chk("rs_proc_rst", {31'd0, proc_rst}, 32'd1);
    chk("rs_in_rdy", {31'd0, in_rdy}, 32'd1);
    chk("rs_words", words_written, 32'd0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_in_rdy"}, {31'd0, in_rdy}, 32'd1);
    chk({tag, "_val"}, {31'd0, ext_dmemreq_val}, 32'd0);
    chk({tag, "_type"}, {31'd0, ext_dmemreq_type}, 32'd0);
    chk({tag, "_addr"}, ext_dmemreq_addr, 32'd0);
    chk({tag, "_wdata"}, ext_dmemreq_wdata, 32'd0);
    chk({tag, "_proc_rst"}, {31'd0, proc_rst}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_words"}, words_written, 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic [31:0] nw);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_proc_rst"}, {31'd0, proc_rst}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_in_rdy"}, {31'd0, in_rdy}, 32'd0);
    chk({tag, "_words"}, words_written, nw);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int e;
    @(negedge clk);
    reset_vals("rst0");
    rst = 1'b1;

    // 1: two words, back-to-back bytes
    dat[0] = 32'h11223344;
    dat[1] = 32'hAABBCCDD;
    load(32'h00000100, 32'd2, 2, 0, 1'b0);
    chk_done("t1", 32'd2);
    chk("t1_last_addr", last_addr, 32'h00000104);

    // 2: zero-length load finishes right after the header
    restart();
    load(32'h00000200, 32'd0, 0, 0, 1'b0);
    chk_done("t2", 32'd0);

    // 3: misaligned address, then recovery
    restart();
    send_word(32'h00000102, 0, e);
    @(negedge clk);
    in_val = 1'b1;
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_proc_rst", {31'd0, proc_rst}, 32'd1);
    chk("t3_in_rdy", {31'd0, in_rdy}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    in_val = 1'b0;
    chk("t3_err_hold", {31'd0, err}, 32'd1);
    restart();
    dat[0] = 32'hDEADBEEF;
    load(32'h00000300, 32'd1, 1, 0, 1'b0);
    chk_done("t3b", 32'd1);

    // 4a: count one past the limit
    restart();
    load(32'h00000400, 32'd257, 0, 0, 1'b0);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_proc_rst", {31'd0, proc_rst}, 32'd1);
    chk("t4_words", words_written, 32'd0);

    // 4b: maximum count ending at the top of the address space
    restart();
    for (int k = 0; k < 256; k++) dat[k] = (32'(k) * 32'h01010101) ^ 32'h5A00A500;
    load(32'hFFFFFC00, 32'd256, 256, 0, 1'b0);
    chk_done("t4b", 32'd256);
    chk("t4b_last_addr", last_addr, 32'hFFFFFFFC);

    // 5: asynchronous reset in the middle of the second data word
    restart();
    dat[0] = 32'h11223344;
    send_word(32'h00000100, 0, e);
    send_word(32'd2, 0, e);
    send_word(dat[0], 0, e);
    sb.push_back('{addr: 32'h00000100, wdata: 32'h11223344, cyc: e});
    send_byte(8'hDD, 0, e);
    send_byte(8'hCC, 0, e);
    #3;
    rst = 1'b0;
    #1;
    reset_vals("t5rst");
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);
    in_val = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    dat[0] = 32'hCAFEF00D;
    dat[1] = 32'h0BADC0DE;
    load(32'h00000500, 32'd2, 2, 0, 1'b0);
    chk_done("t5", 32'd2);

    // 6: random gaps plus an ignored load_start while in DATA
    restart();
    dat[0] = 32'h11223344;
    dat[1] = 32'hAABBCCDD;
    load(32'h00000100, 32'd2, 2, 50, 1'b1);
    chk_done("t6", 32'd2);
    chk("t6_last_addr", last_addr, 32'h00000104);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
